// File: rtl/fpa_pkg.sv
// Shared definitions for the floating-point accumulator slice.
// Provides default field widths, the derived word width, the +0 encoding
// and the accumulator FSM state type.
package fpa_pkg;

  localparam int EXP_WIDTH      = 8;
  localparam int MANTISSA_WIDTH = 23;
  localparam int FP_WIDTH       = 1 + EXP_WIDTH + MANTISSA_WIDTH;

  localparam logic [FP_WIDTH-1:0] FP_POS_ZERO = {FP_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/fp_adder.sv
// Combinational IEEE-style floating-point adder.
// Ports:
//   a_in, b_in     : operands {sign, exponent, mantissa}
//   fpa_out        : sum, truncated (round toward zero)
//   overflow_out   : result exponent reached all-ones; fpa_out is signed infinity
//   underflow_out  : nonzero result fell below the normal range; fpa_out is signed zero
// Zero-exponent operands are treated as zero (denormals flushed).
module fp_adder #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] a_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] b_in,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0] fpa_out,
  output logic                              overflow_out,
  output logic                              underflow_out
);

  localparam int FW   = 1 + EXP_WIDTH + MANTISSA_WIDTH;
  localparam int SW   = MANTISSA_WIDTH + 4;  // hidden bit + mantissa + 3 guard bits
  localparam int EMAX = (1 << EXP_WIDTH) - 1;

  logic [FW-1:0]             big_s, small_s;
  logic [EXP_WIDTH-1:0]      big_exp_s, small_exp_s, exp_diff_s;
  logic [SW-1:0]             big_sig_s, small_sig_s, small_al_s;
  logic [SW:0]               sum_s, norm_s;
  logic                      a_zero_s, b_zero_s;
  int                        lead_s;
  int                        exp_res_s;

  // Align, add/subtract magnitudes, normalise and classify the result.
  always_comb begin
    a_zero_s    = (a_in[FW-2 -: EXP_WIDTH] == {EXP_WIDTH{1'b0}});
    b_zero_s    = (b_in[FW-2 -: EXP_WIDTH] == {EXP_WIDTH{1'b0}});
    // Order by magnitude so the subtraction below never goes negative.
    if (a_in[FW-2:0] < b_in[FW-2:0]) begin
      big_s   = b_in;
      small_s = a_in;
    end else begin
      big_s   = a_in;
      small_s = b_in;
    end
    big_exp_s   = big_s[FW-2 -: EXP_WIDTH];
    small_exp_s = small_s[FW-2 -: EXP_WIDTH];
    exp_diff_s  = big_exp_s - small_exp_s;
    big_sig_s   = {1'b1, big_s[MANTISSA_WIDTH-1:0], 3'b000};
    small_sig_s = {1'b1, small_s[MANTISSA_WIDTH-1:0], 3'b000};
    small_al_s  = (int'(exp_diff_s) >= SW) ? {SW{1'b0}} : (small_sig_s >> exp_diff_s);
    if (big_s[FW-1] == small_s[FW-1]) begin
      sum_s = {1'b0, big_sig_s} + {1'b0, small_al_s};
    end else begin
      sum_s = {1'b0, big_sig_s} - {1'b0, small_al_s};
    end
    lead_s = 0;
    for (int i = 0; i <= SW; i++) begin
      lead_s = sum_s[i] ? i : lead_s;
    end
    exp_res_s = int'(big_exp_s) + lead_s - (SW - 1);
    norm_s    = (lead_s == SW) ? (sum_s >> 1) : (sum_s << (SW - 1 - lead_s));

    overflow_out  = 1'b0;
    underflow_out = 1'b0;
    if (a_zero_s) begin
      fpa_out = b_in;
    end else if (b_zero_s) begin
      fpa_out = a_in;
    end else if (sum_s == {(SW+1){1'b0}}) begin
      fpa_out = {FW{1'b0}};  // exact cancellation gives +0
    end else if (exp_res_s >= EMAX) begin
      fpa_out      = {big_s[FW-1], {EXP_WIDTH{1'b1}}, {MANTISSA_WIDTH{1'b0}}};
      overflow_out = 1'b1;
    end else if (exp_res_s <= 0) begin
      fpa_out       = {big_s[FW-1], {(FW-1){1'b0}}};
      underflow_out = 1'b1;
    end else begin
      fpa_out = {big_s[FW-1], exp_res_s[EXP_WIDTH-1:0], norm_s[SW-2:3]};
    end
  end

endmodule

// File: rtl/fp_accumulator.sv
// Packet accumulator around fp_adder.
// Ports:
//   clk_in, rst_in             : clock, asynchronous active-high reset
//   data_in/valid_in/last_in   : input beat stream, ready_out is its backpressure
//   sum_out/count_out          : packet sum and saturating beat count
//   overflow_out/underflow_out : sticky adder flags for the packet
//   sum_valid_out/sum_ready_in : result handshake
module fp_accumulator
  import fpa_pkg::*;
#(
  parameter int EXP_WIDTH      = fpa_pkg::EXP_WIDTH,
  parameter int MANTISSA_WIDTH = fpa_pkg::MANTISSA_WIDTH,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] data_in,
  input  logic                              valid_in,
  input  logic                              last_in,
  output logic                              ready_out,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0] sum_out,
  output logic                              sum_valid_out,
  input  logic                              sum_ready_in,
  output logic [COUNT_WIDTH-1:0]            count_out,
  output logic                              overflow_out,
  output logic                              underflow_out
);

  localparam int FW = 1 + EXP_WIDTH + MANTISSA_WIDTH;

  acc_state_t             state_r, state_next_s;
  logic [FW-1:0]          acc_r, add_sum_s;
  logic [COUNT_WIDTH-1:0] count_r;
  logic                   ovf_r, unf_r, add_ovf_s, add_unf_s;
  logic                   accept_s, release_s;

  fp_adder #(
    .EXP_WIDTH      (EXP_WIDTH),
    .MANTISSA_WIDTH (MANTISSA_WIDTH)
  ) u_fp_adder (
    .a_in          (acc_r),
    .b_in          (data_in),
    .fpa_out       (add_sum_s),
    .overflow_out  (add_ovf_s),
    .underflow_out (add_unf_s)
  );

  assign accept_s  = valid_in && ready_out;
  assign release_s = (state_r == HOLD) && sum_ready_in;

  // FSM state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, ACCUM: begin
        if (accept_s) begin
          state_next_s = last_in ? HOLD : ACCUM;
        end else begin
          state_next_s = state_r;
        end
      end
      HOLD: begin
        if (sum_ready_in) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output decode; both outputs are direct decodes of the state register.
  always_comb begin
    ready_out     = 1'b1;
    sum_valid_out = 1'b0;
    case (state_r)
      IDLE, ACCUM: begin
        ready_out     = 1'b1;
        sum_valid_out = 1'b0;
      end
      HOLD: begin
        ready_out     = 1'b0;
        sum_valid_out = 1'b1;
      end
      default: begin
        ready_out     = 1'b0;
        sum_valid_out = 1'b0;
      end
    endcase
  end

  // Running sum, saturating count and sticky flags; cleared on result handoff.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_r   <= {FW{1'b0}};
      count_r <= {COUNT_WIDTH{1'b0}};
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else if (accept_s) begin
      acc_r   <= add_sum_s;
      count_r <= (&count_r) ? count_r : (count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1});
      ovf_r   <= ovf_r | add_ovf_s;
      unf_r   <= unf_r | add_unf_s;
    end else if (release_s) begin
      acc_r   <= {FW{1'b0}};
      count_r <= {COUNT_WIDTH{1'b0}};
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      acc_r   <= acc_r;
      count_r <= count_r;
      ovf_r   <= ovf_r;
      unf_r   <= unf_r;
    end
  end

  assign sum_out       = acc_r;
  assign count_out     = count_r;
  assign overflow_out  = ovf_r;
  assign underflow_out = unf_r;

endmodule

// File: tb/tb_fp_accumulator.sv
module tb_fp_accumulator;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] data_in;
  logic        valid_in;
  logic        last_in;
  logic        ready_out;
  logic [31:0] sum_out;
  logic        sum_valid_out;
  logic        sum_ready_in;
  logic [15:0] count_out;
  logic        overflow_out;
  logic        underflow_out;

  int tests_run = 0;
  int tests_failed = 0;

  fp_accumulator dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .last_in       (last_in),
    .ready_out     (ready_out),
    .sum_out       (sum_out),
    .sum_valid_out (sum_valid_out),
    .sum_ready_in  (sum_ready_in),
    .count_out     (count_out),
    .overflow_out  (overflow_out),
    .underflow_out (underflow_out)
  );

  always #5 clk_in = ~clk_in;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Present one beat for one edge (ready_out is high in IDLE/ACCUM).
  task automatic beat(input logic [31:0] d, input logic l);
    data_in  = d;
    valid_in = 1'b1;
    last_in  = l;
    tick();
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; valid_in = 1'b0; last_in = 1'b0; data_in = 32'h0; sum_ready_in = 1'b0;
    tick(); tick();
    rst_in = 1'b0;
    tick();
    tests_run++;
    if (sum_valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", sum_valid_out); end
    tests_run++;
    if (ready_out !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", ready_out); end
    tests_run++;
    if (sum_out !== 32'h0 || count_out !== 16'd0) begin tests_failed++; $display("FAIL reset_regs: sum %h count %0d want 0/0", sum_out, count_out); end
    tests_run++;
    if ({overflow_out, underflow_out} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags: got %b want 00", {overflow_out, underflow_out}); end
  endtask

  task automatic test_basic();
    sum_ready_in = 1'b1;
    beat(32'h3F800000, 1'b0);
    beat(32'h40000000, 1'b0);
    beat(32'h40400000, 1'b1);
    tests_run++;
    if (sum_valid_out !== 1'b1 || sum_out !== 32'h40C00000) begin tests_failed++; $display("FAIL basic_sum: valid %b sum %h want 1/40c00000", sum_valid_out, sum_out); end
    tests_run++;
    if (count_out !== 16'd3 || {overflow_out, underflow_out} !== 2'b00) begin tests_failed++; $display("FAIL basic_count: count %0d flags %b want 3/00", count_out, {overflow_out, underflow_out}); end
    tick();
    tests_run++;
    if (sum_valid_out !== 1'b0 || ready_out !== 1'b1) begin tests_failed++; $display("FAIL basic_one_cycle: valid %b ready %b want 0/1", sum_valid_out, ready_out); end
  endtask

  task automatic test_single();
    sum_ready_in = 1'b0;
    beat(32'hC0A00000, 1'b1);
    tests_run++;
    if (sum_valid_out !== 1'b1 || sum_out !== 32'hC0A00000 || count_out !== 16'd1) begin tests_failed++; $display("FAIL single: valid %b sum %h count %0d want 1/c0a00000/1", sum_valid_out, sum_out, count_out); end
    sum_ready_in = 1'b1;
    tick();
    tests_run++;
    if (sum_valid_out !== 1'b0 || count_out !== 16'd0) begin tests_failed++; $display("FAIL single_release: valid %b count %0d want 0/0", sum_valid_out, count_out); end
  endtask

  task automatic test_overflow();
    sum_ready_in = 1'b0;
    beat(32'h7F7FFFFF, 1'b0);
    beat(32'h7F7FFFFF, 1'b1);
    tests_run++;
    if (sum_valid_out !== 1'b1 || overflow_out !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: valid %b ovf %b want 1/1", sum_valid_out, overflow_out); end
    tests_run++;
    if (sum_out !== 32'h7F800000 || count_out !== 16'd2) begin tests_failed++; $display("FAIL ovf_sum: sum %h count %0d want 7f800000/2", sum_out, count_out); end
    sum_ready_in = 1'b1;
    tick();
    beat(32'h3F800000, 1'b1);
    tests_run++;
    if (sum_valid_out !== 1'b1 || overflow_out !== 1'b0 || sum_out !== 32'h3F800000) begin tests_failed++; $display("FAIL ovf_cleared: valid %b ovf %b sum %h want 1/0/3f800000", sum_valid_out, overflow_out, sum_out); end
    tick();
  endtask

  task automatic test_backpressure();
    sum_ready_in = 1'b0;
    beat(32'h3F800000, 1'b0);
    beat(32'h40000000, 1'b1);
    data_in = 32'h3F800000; valid_in = 1'b1; last_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (ready_out !== 1'b0 || sum_valid_out !== 1'b1 || sum_out !== 32'h40400000 || count_out !== 16'd2) begin
        tests_failed++;
        $display("FAIL hold_stable[%0d]: ready %b valid %b sum %h count %0d want 0/1/40400000/2", i, ready_out, sum_valid_out, sum_out, count_out);
      end
      tick();
    end
    sum_ready_in = 1'b1;
    tick();
    tests_run++;
    if (ready_out !== 1'b1 || sum_valid_out !== 1'b0 || count_out !== 16'd0) begin tests_failed++; $display("FAIL hold_release: ready %b valid %b count %0d want 1/0/0", ready_out, sum_valid_out, count_out); end
    sum_ready_in = 1'b0;
    tick();
    valid_in = 1'b0; last_in = 1'b0;
    tests_run++;
    if (sum_valid_out !== 1'b1 || sum_out !== 32'h3F800000 || count_out !== 16'd1) begin tests_failed++; $display("FAIL pending_beat: valid %b sum %h count %0d want 1/3f800000/1", sum_valid_out, sum_out, count_out); end
    sum_ready_in = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    sum_ready_in = 1'b1;
    beat(32'h3F800000, 1'b0);
    beat(32'h40000000, 1'b0);
    tests_run++;
    if (count_out !== 16'd2 || sum_out !== 32'h40400000) begin tests_failed++; $display("FAIL pre_reset: count %0d sum %h want 2/40400000", count_out, sum_out); end
    #2 rst_in = 1'b1;
    #1;
    tests_run++;
    if (count_out !== 16'd0 || sum_out !== 32'h0 || ready_out !== 1'b1 || sum_valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: count %0d sum %h ready %b valid %b want 0/0/1/0", count_out, sum_out, ready_out, sum_valid_out);
    end
    #1 rst_in = 1'b0;
    tick();
    beat(32'h40800000, 1'b1);
    tests_run++;
    if (sum_valid_out !== 1'b1 || sum_out !== 32'h40800000 || count_out !== 16'd1) begin tests_failed++; $display("FAIL post_reset: valid %b sum %h count %0d want 1/40800000/1", sum_valid_out, sum_out, count_out); end
    tick();
  endtask

  task automatic test_ignored_last();
    sum_ready_in = 1'b1;
    beat(32'h3F800000, 1'b0);
    data_in = 32'h40000000; valid_in = 1'b0; last_in = 1'b1;
    tick();
    last_in = 1'b0;
    tests_run++;
    if (sum_valid_out !== 1'b0 || count_out !== 16'd1) begin tests_failed++; $display("FAIL ignored_last: valid %b count %0d want 0/1", sum_valid_out, count_out); end
    beat(32'h3F800000, 1'b1);
    tests_run++;
    if (sum_valid_out !== 1'b1 || sum_out !== 32'h40000000 || count_out !== 16'd2) begin tests_failed++; $display("FAIL ignored_sum: valid %b sum %h count %0d want 1/40000000/2", sum_valid_out, sum_out, count_out); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_ignored_last();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fp_accumulator.md
Name: fp_accumulator

Overview:
- Sequential stage directly upstream of and wrapping the combinational fp_adder.
- Takes a valid/ready stream of IEEE-style floats, folds each beat into a running sum through fp_adder, and presents the packet sum on a valid/ready output when the beat flagged last is accepted.
- Overflow and underflow from the adder are captured as sticky, per-packet flags.

Parameters:
- EXP_WIDTH, 8, exponent field width passed to fp_adder.
- MANTISSA_WIDTH, 23, mantissa field width passed to fp_adder.
- COUNT_WIDTH, 16, width of the beat counter.

Ports:
- clk_in  input  1  single clock, rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- data_in  input  1+EXP_WIDTH+MANTISSA_WIDTH  operand beat.
- valid_in  input  1  data_in/last_in qualified.
- last_in  input  1  final beat of the packet.
- ready_out  output  1  block accepts a beat this cycle.
- sum_out  output  1+EXP_WIDTH+MANTISSA_WIDTH  packet sum.
- sum_valid_out  output  1  sum_out, flags and count valid.
- sum_ready_in  input  1  consumer takes the sum.
- count_out  output  COUNT_WIDTH  beats in the packet, saturating.
- overflow_out  output  1  sticky: an adder overflow occurred in the packet.
- underflow_out  output  1  sticky: an adder underflow occurred in the packet.

Behaviour:
- Reset is asynchronous and active-high; clock is single.
- Reset values: state=IDLE, acc=+0 (all zeros), count=0, sticky flags=0, sum_valid_out=0, ready_out=1 after reset deasserts.
- Accept condition: a beat is accepted when valid_in && ready_out at a rising edge.
- ready_out = (state != HOLD).
- Datapath: fp_adder a_in=acc, b_in=data_in, combinational. On accept:
  - acc <= fpa_out.
  - ovf <= ovf | overflow_out(adder).
  - unf <= unf | underflow_out(adder).
  - count <= count+1, saturating at all-ones.
- FSM IDLE:
  - acc=+0, count=0, flags=0.
  - Accept with last_in=0 -> ACCUM.
  - Accept with last_in=1 -> HOLD.
- FSM ACCUM:
  - Accept with last_in=0 -> stay.
  - Accept with last_in=1 -> HOLD.
  - No accept -> stay, all registers hold.
- FSM HOLD:
  - sum_valid_out=1.
  - sum_out, count_out and flags are stable registered values.
  - When sum_ready_in=1: clear acc, count and flags; go to IDLE.
  - sum_ready_in=0 -> stay; outputs must not change.
- Latency: sum_valid_out rises on the edge that accepts the last beat, i.e. one cycle after the last beat is presented with ready_out high.
- Throughput: one beat per cycle in IDLE/ACCUM. There is one bubble per packet: the HOLD cycle(s) plus the IDLE entry.
- A beat presented during HOLD is not accepted. The producer must hold it; it is accepted in IDLE on the cycle after the handshake.
- sum_ready_in outside HOLD is ignored.
- The single-beat packet yields sum = +0 + x = x, as computed by fp_adder.
- last_in is ignored unless valid_in is high.
- Count saturation: at all-ones the count stays; accumulation continues.
- Overflow/underflow values: sum_out carries whatever fp_adder produced; the block does no special-value handling of its own.
- Reset asserted mid-packet or in HOLD: all state returns to reset values immediately, without waiting for a clock edge. The partial sum is discarded and no sum_valid_out is produced.
- Outputs sum_out, count_out and the flags are registered. They are don't-care when sum_valid_out=0, but are driven from the registers.

Decomposition:
- Shared package fpa_pkg:
  - EXP_WIDTH and MANTISSA_WIDTH defaults.
  - Derived FP_WIDTH.
  - FP_POS_ZERO constant.
  - Enum typedef acc_state_t {IDLE, ACCUM, HOLD}.
- Sub-module: the existing fp_adder, instantiated once with matching parameters; no new sub-module.
- The FSM and registers live in fp_accumulator itself.

Test Plan:
- Stream 3F800000 (1.0), 40000000 (2.0), 40400000 (3.0, last) back-to-back, sum_ready_in=1.
  -> sum_out=40C00000, count_out=3, flags 0, sum_valid_out high for exactly 1 cycle.
- Single beat C0A00000 (-5.0) with last.
  -> sum_out=C0A00000, count_out=1, sum_valid_out on the next edge.
- Beats 7F7FFFFF, 7F7FFFFF (last).
  -> overflow_out=1 with sum_valid_out; the next packet 3F800000 (last) reports overflow_out=0.
- Packet 1.0, 2.0 (last); hold sum_ready_in=0 for 5 cycles while valid_in stays high with 3F800000.
  -> ready_out=0 and sum_out=40400000 stable for 5 cycles. The pending beat is accepted the cycle after the handshake as the start of a new packet.
- Accept 1.0 and 2.0 without last, pulse rst_in mid-cycle, then send 40800000 (4.0, last).
  -> outputs clear asynchronously; the result is 40800000 with count_out=1.
- Beat with valid_in=0 and last_in=1 between beats 1.0 and 1.0 (last).
  -> ignored; sum_out=40000000, count_out=2.
